rng_seq_ctrl: RTL and testbench
===============================

Name: rng_seq_ctrl

Overview:
- Sequencer for the tag random-number generator: converts decoded Gen2 inventory/access commands into non-overlapping Q_update / slot_update / rn16_update / handle_update strobes.
- Owns the current Q value, including QueryAdjust arithmetic.
- Samples the generator's slot_valid and tells the reply path whether to backscatter an RN16 or handle.
- Sits between the command decoder and the RNG; everything runs on DOUB_BLF.

Parameters:
- PULSE_W, 2: strobe high time in DOUB_BLF cycles (1..15).
- GAP_W, 2: mandatory low time after each strobe, covering the RNG falling-edge shift and register delay (1..15).

Ports:
- DOUB_BLF  in  1  clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command strobe; accepted only when cmd_ready=1.
- cmd_type  in  3  0=QUERY, 1=QUERYREP, 2=QUERYADJ, 3=REQ_HANDLE, 4=REQ_RN; 5..7 illegal.
- cmd_q  in  4  Q field, used for QUERY only.
- cmd_updn  in  3  QueryAdjust UpDn: 110=Q+1, 011=Q-1, 000=hold; others illegal.
- slot_valid  in  1  from RNG; high when the slot counter hits zero under the current Q.
- cmd_ready  out  1  high in IDLE only.
- Q  out  4  current Q, driven to the RNG.
- Q_update, slot_update, rn16_update, handle_update  out  1 each  RNG strobes.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_type  out  2  valid with rsp_valid: 0=no reply, 1=reply RN16, 2=reply handle.
- rsp_err  out  1  one-cycle pulse for an illegal cmd_type or UpDn; no strobes are issued.

Behaviour:
- Reset: every strobe 0, Q=0, rsp_valid=0, rsp_type=0, rsp_err=0, state IDLE, cmd_ready=1.
- Reset is asynchronous at any point, including mid-strobe; strobes drop immediately.
- Strobe rules: at most one strobe is high at any time. Every strobe is high for exactly PULSE_W cycles, then all strobes stay low for at least GAP_W cycles.
- States:
  - IDLE: on cmd_valid & cmd_ready, latch the command and go to DECODE.
  - DECODE (1 cycle):
    - Illegal cmd_type or UpDn: pulse rsp_err, return to IDLE.
    - QUERY: Q<=cmd_q.
    - QUERYADJ: Q<=Q+1 saturating at 15, or Q-1 saturating at 0, or hold.
    - Select the first strobe: Q_update for QUERY/QUERYADJ, slot_update for QUERYREP, handle_update for REQ_HANDLE, rn16_update for REQ_RN. Go to STROBE.
  - STROBE: drive the selected strobe for PULSE_W cycles, then go to GAP.
  - GAP: GAP_W low cycles, then:
    - after Q_update or slot_update, go to CHECK;
    - after rn16_update, go to DONE with type 1, unless it was a REQ_RN, which also ends with type 1;
    - after handle_update, go to DONE with type 2.
  - CHECK (1 cycle): sample slot_valid.
    - 1: select rn16_update and go to STROBE.
    - 0: go to DONE with type 0.
  - DONE: rsp_valid=1 for one cycle with rsp_type, then IDLE.
- Latency with defaults (cmd_valid to rsp_valid):
  - QUERY hit: 1+2+2+1+2+2+1 = 11 cycles.
  - QUERY miss: 7 cycles.
  - REQ_RN/REQ_HANDLE: 6 cycles.
- cmd_valid while cmd_ready=0 is ignored: not queued, no error.
- Q changes only in DECODE and is stable across all strobes, because the RNG evaluates slot_valid combinationally from Q.
- QUERYADJ with UpDn=000 still reloads the slot: issues Q_update, identical to QUERY with the current Q.
- QUERYREP at slot 0 is not special-cased: the RNG counter wraps and the miss/hit result is reported as sampled.

Optional Feature:
- RNG_SLOT_CNT_EN defined:
  - Adds output slot_cnt[15:0].
  - Cleared to 0 on reset and in DECODE of QUERY/QUERYADJ.
  - Incremented, saturating at 16'hFFFF, in DECODE of QUERYREP.
  - Gives the bench/debug a count of QueryReps since the last Q load.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then QUERY cmd_q=0 -> Q=0; Q_update high 2 cycles; 2 low; slot_valid=1 sampled; rn16_update 2 cycles; rsp_valid at cycle 11 with rsp_type=1.
- QUERY cmd_q=4 with slot_valid forced 0 -> only Q_update pulses; rsp_type=0 at cycle 7; no rn16_update.
- QUERYADJ UpDn=110 at Q=15, then UpDn=011 at Q=0 -> Q stays 15, then stays 0; Q_update issued each time.
- REQ_HANDLE then REQ_RN -> handle_update (rsp_type=2), then rn16_update (rsp_type=1). Monitor checks no two strobes ever overlap and GAP_W low cycles are always present.
- cmd_type=6 and QUERYADJ UpDn=101 -> rsp_err one-cycle pulse each, no strobes, Q unchanged. cmd_valid asserted while busy -> ignored.
- Assert rst during the rn16_update high phase -> strobe low immediately, Q=0, cmd_ready=1. After release, QUERY runs normally. With RNG_SLOT_CNT_EN: 3×QUERYREP -> slot_cnt=3; next QUERY -> 0.

Source files
------------

// File: rtl/rng_seq_ctrl.sv
// Sequencer for the tag RNG: turns decoded Gen2 commands into non-overlapping RNG strobes.
// Optional RNG_SLOT_CNT_EN adds a slot_cnt output counting QueryReps since the last Q load.
module rng_seq_ctrl #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       DOUB_BLF,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [2:0] cmd_type,
    input  logic [3:0] cmd_q,
    input  logic [2:0] cmd_updn,
    input  logic       slot_valid,
    output logic       cmd_ready,
    output logic [3:0] Q,
    output logic       Q_update,
    output logic       slot_update,
    output logic       rn16_update,
    output logic       handle_update,
    output logic       rsp_valid,
    output logic [1:0] rsp_type,
    output logic       rsp_err
`ifdef RNG_SLOT_CNT_EN
    ,
    output logic [15:0] slot_cnt
`endif
);

    localparam logic [2:0] CMD_QUERY  = 3'd0;
    localparam logic [2:0] CMD_QREP   = 3'd1;
    localparam logic [2:0] CMD_QADJ   = 3'd2;
    localparam logic [2:0] CMD_HANDLE = 3'd3;
    localparam logic [2:0] CMD_RN     = 3'd4;

    localparam logic [2:0] UPDN_INC  = 3'b110;
    localparam logic [2:0] UPDN_DEC  = 3'b011;
    localparam logic [2:0] UPDN_HOLD = 3'b000;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_STROBE,
        S_GAP,
        S_CHECK,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        STB_Q,
        STB_SLOT,
        STB_RN16,
        STB_HANDLE
    } strobe_e;

    state_e     state_q, state_d;
    strobe_e    sel_q, sel_d;
    logic [2:0] ctype_q, ctype_d;
    logic [3:0] cq_q, cq_d;
    logic [2:0] updn_q, updn_d;
    logic [3:0] q_q, q_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] rtype_q, rtype_d;
    logic       cmd_illegal;
    logic [3:0] q_adj;
`ifdef RNG_SLOT_CNT_EN
    logic [15:0] slot_cnt_q, slot_cnt_d;
`endif

    // UpDn is only meaningful for QueryAdjust; other commands ignore it.
    always_comb begin
        cmd_illegal = 1'b0;
        if (ctype_q > CMD_RN) begin
            cmd_illegal = 1'b1;
        end else if (ctype_q == CMD_QADJ &&
                     updn_q != UPDN_INC && updn_q != UPDN_DEC && updn_q != UPDN_HOLD) begin
            cmd_illegal = 1'b1;
        end
    end

    always_comb begin
        q_adj = q_q;
        if (updn_q == UPDN_INC && q_q != 4'hF) begin
            q_adj = q_q + 4'd1;
        end else if (updn_q == UPDN_DEC && q_q != 4'h0) begin
            q_adj = q_q - 4'd1;
        end
    end

    always_ff @(posedge DOUB_BLF or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= STB_Q;
            ctype_q <= '0;
            cq_q    <= '0;
            updn_q  <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            rtype_q <= '0;
`ifdef RNG_SLOT_CNT_EN
            slot_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ctype_q <= ctype_d;
            cq_q    <= cq_d;
            updn_q  <= updn_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            rtype_q <= rtype_d;
`ifdef RNG_SLOT_CNT_EN
            slot_cnt_q <= slot_cnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ctype_d = ctype_q;
        cq_d    = cq_q;
        updn_d  = updn_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        rtype_d = rtype_q;
`ifdef RNG_SLOT_CNT_EN
        slot_cnt_d = slot_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    ctype_d = cmd_type;
                    cq_d    = cmd_q;
                    updn_d  = cmd_updn;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmd_illegal) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                    case (ctype_q)
                        CMD_QUERY: begin
                            q_d   = cq_q;
                            sel_d = STB_Q;
                        end
                        CMD_QADJ: begin
                            q_d   = q_adj;
                            sel_d = STB_Q;
                        end
                        CMD_QREP:   sel_d = STB_SLOT;
                        CMD_HANDLE: sel_d = STB_HANDLE;
                        default:    sel_d = STB_RN16;
                    endcase
`ifdef RNG_SLOT_CNT_EN
                    if (ctype_q == CMD_QUERY || ctype_q == CMD_QADJ) begin
                        slot_cnt_d = '0;
                    end else if (ctype_q == CMD_QREP && slot_cnt_q != 16'hFFFF) begin
                        slot_cnt_d = slot_cnt_q + 16'd1;
                    end
`endif
                end
            end
            S_STROBE: begin
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    case (sel_q)
                        STB_Q, STB_SLOT: state_d = S_CHECK;
                        STB_RN16: begin
                            rtype_d = 2'd1;
                            state_d = S_DONE;
                        end
                        default: begin
                            rtype_d = 2'd2;
                            state_d = S_DONE;
                        end
                    endcase
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            S_CHECK: begin
                // Q is already stable here, so slot_valid reflects the new slot counter.
                if (slot_valid) begin
                    sel_d   = STB_RN16;
                    cnt_d   = '0;
                    state_d = S_STROBE;
                end else begin
                    rtype_d = 2'd0;
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an async reset drops strobes at once.
    always_comb begin
        cmd_ready     = 1'b0;
        Q_update      = 1'b0;
        slot_update   = 1'b0;
        rn16_update   = 1'b0;
        handle_update = 1'b0;
        rsp_valid     = 1'b0;
        rsp_type      = 2'd0;
        rsp_err       = 1'b0;
        case (state_q)
            S_IDLE:   cmd_ready = 1'b1;
            S_DECODE: rsp_err = cmd_illegal;
            S_STROBE: begin
                case (sel_q)
                    STB_Q:    Q_update      = 1'b1;
                    STB_SLOT: slot_update   = 1'b1;
                    STB_RN16: rn16_update   = 1'b1;
                    default:  handle_update = 1'b1;
                endcase
            end
            S_DONE: begin
                rsp_valid = 1'b1;
                rsp_type  = rtype_q;
            end
            default: ;
        endcase
    end

    assign Q = q_q;
`ifdef RNG_SLOT_CNT_EN
    assign slot_cnt = slot_cnt_q;
`endif

endmodule

// File: tb/tb_rng_seq_ctrl.sv
// Randomized bench for rng_seq_ctrl: a command-level model predicts Q, strobe order,
// latency and response; a monitor watches strobe exclusivity, pulse width and gaps.
module tb_rng_seq_ctrl;
    localparam int P = 2;
    localparam int G = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_type = '0;
    logic [3:0] cmd_q = '0;
    logic [2:0] cmd_updn = '0;
    logic       slot_valid = 1'b0;
    logic       cmd_ready, Q_update, slot_update, rn16_update, handle_update;
    logic       rsp_valid, rsp_err;
    logic [3:0] Q;
    logic [1:0] rsp_type;
`ifdef RNG_SLOT_CNT_EN
    logic [15:0] slot_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rng_seq_ctrl #(.PULSE_W(P), .GAP_W(G)) dut (
        .DOUB_BLF(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
        .cmd_q(cmd_q), .cmd_updn(cmd_updn), .slot_valid(slot_valid),
        .cmd_ready(cmd_ready), .Q(Q), .Q_update(Q_update), .slot_update(slot_update),
        .rn16_update(rn16_update), .handle_update(handle_update),
        .rsp_valid(rsp_valid), .rsp_type(rsp_type), .rsp_err(rsp_err)
`ifdef RNG_SLOT_CNT_EN
        , .slot_cnt(slot_cnt)
`endif
    );

    // ---------------- strobe monitor ----------------
    logic [3:0] strb;
    logic [3:0] prev_strb = '0;
    logic [3:0] q_at = '0;
    int hi_run = 0;
    int lo_run = 99;
    int mon_viol = 0;
    int unsigned strb_log[$];

    assign strb = {handle_update, rn16_update, slot_update, Q_update};

    function automatic int unsigned code_of(input logic [3:0] s);
        case (s)
            4'b0001: return 1;
            4'b0010: return 2;
            4'b0100: return 3;
            4'b1000: return 4;
            default: return 15;
        endcase
    endfunction

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            hi_run    <= 0;
            lo_run    <= 99;
            prev_strb <= '0;
        end else begin
            prev_strb <= strb;
            if (!$onehot0(strb)) mon_viol <= mon_viol + 1;
            if (strb != 4'b0) begin
                hi_run <= hi_run + 1;
                lo_run <= 0;
                if (hi_run == 0) begin
                    if (lo_run < G) mon_viol <= mon_viol + 1;
                    q_at <= Q;
                    strb_log.push_back(code_of(strb));
                end else if (strb != prev_strb || Q != q_at || hi_run >= P) begin
                    mon_viol <= mon_viol + 1;
                end
            end else begin
                if (hi_run != 0 && hi_run != P) mon_viol <= mon_viol + 1;
                hi_run <= 0;
                lo_run <= lo_run + 1;
            end
        end
    end

    // ---------------- command-level reference model ----------------
    // kind: 1=rsp_valid, 2=rsp_err; seq: strobe codes in issue order, one nibble each.
    function automatic void model(input logic [2:0] t, input logic [3:0] cq,
                                  input logic [2:0] ud, input logic sv, input int qin,
                                  output int kind, output int lat, output int typ,
                                  output int unsigned seq, output int qout);
        int first;
        qout = qin;
        seq = 0;
        typ = 0;
        if (t > 4 || (t == 2 && !(ud == 3'b110 || ud == 3'b011 || ud == 3'b000))) begin
            kind = 2;
            lat  = 1;
            return;
        end
        kind = 1;
        if (t == 0) qout = int'(cq);
        if (t == 2 && ud == 3'b110) qout = (qin == 15) ? 15 : qin + 1;
        if (t == 2 && ud == 3'b011) qout = (qin == 0) ? 0 : qin - 1;
        case (t)
            0, 2:    first = 1;
            1:       first = 2;
            3:       first = 4;
            default: first = 3;
        endcase
        if (first <= 2) begin
            if (sv) begin
                seq = (int'(first) << 4) | 3;
                typ = 1;
                lat = 1 + 2 * (P + G) + 1 + 1;
            end else begin
                seq = first;
                typ = 0;
                lat = 1 + (P + G) + 1 + 1;
            end
        end else begin
            seq = first;
            typ = (first == 4) ? 2 : 1;
            lat = 1 + (P + G) + 1;
        end
    endfunction

    // ---------------- driver / observer ----------------
    int          obs_kind, obs_lat, obs_type;
    int unsigned obs_seq;
    logic [2:0]  obs_after;

    task automatic issue(input logic [2:0] t, input logic [3:0] cq, input logic [2:0] ud,
                         input logic sv, input bit poke);
        int start;
        start    = strb_log.size();
        obs_kind = 0;
        obs_lat  = 0;
        obs_type = 0;
        @(posedge clk);
        #1;
        slot_valid = sv;
        cmd_valid  = 1'b1;
        cmd_type   = t;
        cmd_q      = cq;
        cmd_updn   = ud;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int lat = 1; lat <= 60; lat++) begin
            @(negedge clk);
            if (rsp_valid) begin
                obs_kind = 1;
                obs_lat  = lat;
                obs_type = int'(rsp_type);
                break;
            end
            if (rsp_err) begin
                obs_kind = 2;
                obs_lat  = lat;
                break;
            end
            if (poke && lat == 3) begin
                cmd_valid = 1'b1;
                cmd_type  = 3'd0;
                cmd_q     = 4'd9;
            end
            if (poke && lat == 4) cmd_valid = 1'b0;
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        obs_after = {rsp_valid, rsp_err, cmd_ready};
        obs_seq = 0;
        for (int i = start; i < strb_log.size(); i++) obs_seq = (obs_seq << 4) | strb_log[i];
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({Q_update, slot_update, rn16_update, handle_update, rsp_valid, rsp_err,
             cmd_ready, rsp_type, Q} !== 13'b0000001_00_0000) begin
            n_fail++;
            $display("FAIL reset_state: got strb=%b rv=%b re=%b rdy=%b rt=%0d Q=%0d, want all 0 with rdy=1",
                     strb, rsp_valid, rsp_err, cmd_ready, rsp_type, Q);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_query_hit();
        issue(3'd0, 4'd0, 3'd0, 1'b1, 1'b0);
        n_chk++;
        if (obs_kind !== 1 || obs_lat !== 11 || obs_type !== 1 || obs_seq !== 32'h13 || Q !== 4'd0) begin
            n_fail++;
            $display("FAIL query_hit: got kind=%0d lat=%0d type=%0d seq=%h Q=%0d, want 1/11/1/13/0",
                     obs_kind, obs_lat, obs_type, obs_seq, Q);
        end
        n_chk++;
        if (obs_after !== 3'b001) begin
            n_fail++;
            $display("FAIL query_hit_after: got %b want 001", obs_after);
        end
    endtask

    task automatic test_query_miss();
        issue(3'd0, 4'd4, 3'd0, 1'b0, 1'b0);
        n_chk++;
        if (obs_kind !== 1 || obs_lat !== 7 || obs_type !== 0 || obs_seq !== 32'h1 || Q !== 4'd4) begin
            n_fail++;
            $display("FAIL query_miss: got kind=%0d lat=%0d type=%0d seq=%h Q=%0d, want 1/7/0/1/4",
                     obs_kind, obs_lat, obs_type, obs_seq, Q);
        end
    endtask

    task automatic test_queryadj_sat();
        issue(3'd0, 4'd15, 3'd0, 1'b0, 1'b0);
        issue(3'd2, 4'd0, 3'b110, 1'b0, 1'b0);
        n_chk++;
        if (Q !== 4'd15 || obs_seq !== 32'h1 || obs_lat !== 7) begin
            n_fail++;
            $display("FAIL qadj_up_sat: got Q=%0d seq=%h lat=%0d, want 15/1/7", Q, obs_seq, obs_lat);
        end
        issue(3'd0, 4'd0, 3'd0, 1'b0, 1'b0);
        issue(3'd2, 4'd7, 3'b011, 1'b0, 1'b0);
        n_chk++;
        if (Q !== 4'd0 || obs_seq !== 32'h1 || obs_lat !== 7) begin
            n_fail++;
            $display("FAIL qadj_dn_sat: got Q=%0d seq=%h lat=%0d, want 0/1/7", Q, obs_seq, obs_lat);
        end
    endtask

    task automatic test_req();
        issue(3'd3, 4'd0, 3'd0, 1'b1, 1'b0);
        n_chk++;
        if (obs_kind !== 1 || obs_lat !== 6 || obs_type !== 2 || obs_seq !== 32'h4) begin
            n_fail++;
            $display("FAIL req_handle: got kind=%0d lat=%0d type=%0d seq=%h, want 1/6/2/4",
                     obs_kind, obs_lat, obs_type, obs_seq);
        end
        issue(3'd4, 4'd0, 3'd0, 1'b0, 1'b0);
        n_chk++;
        if (obs_kind !== 1 || obs_lat !== 6 || obs_type !== 1 || obs_seq !== 32'h3) begin
            n_fail++;
            $display("FAIL req_rn: got kind=%0d lat=%0d type=%0d seq=%h, want 1/6/1/3",
                     obs_kind, obs_lat, obs_type, obs_seq);
        end
    endtask

    task automatic test_illegal();
        issue(3'd0, 4'd5, 3'd0, 1'b0, 1'b0);
        issue(3'd6, 4'd2, 3'd0, 1'b1, 1'b0);
        n_chk++;
        if (obs_kind !== 2 || obs_lat !== 1 || obs_seq !== 32'h0 || Q !== 4'd5 || obs_after !== 3'b001) begin
            n_fail++;
            $display("FAIL illegal_type: got kind=%0d lat=%0d seq=%h Q=%0d after=%b, want 2/1/0/5/001",
                     obs_kind, obs_lat, obs_seq, Q, obs_after);
        end
        issue(3'd2, 4'd0, 3'b101, 1'b1, 1'b0);
        n_chk++;
        if (obs_kind !== 2 || obs_lat !== 1 || obs_seq !== 32'h0 || Q !== 4'd5 || obs_after !== 3'b001) begin
            n_fail++;
            $display("FAIL illegal_updn: got kind=%0d lat=%0d seq=%h Q=%0d after=%b, want 2/1/0/5/001",
                     obs_kind, obs_lat, obs_seq, Q, obs_after);
        end
    endtask

    task automatic test_busy_ignore();
        int n0;
        issue(3'd0, 4'd3, 3'd0, 1'b0, 1'b1);
        n0 = strb_log.size();
        repeat (6) @(negedge clk);
        n_chk++;
        if (Q !== 4'd3 || obs_seq !== 32'h1 || obs_lat !== 7 || strb_log.size() != n0 || cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_ignore: got Q=%0d seq=%h lat=%0d extra_strobes=%0d rdy=%b, want 3/1/7/0/1",
                     Q, obs_seq, obs_lat, strb_log.size() - n0, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        @(posedge clk);
        #1;
        slot_valid = 1'b1;
        cmd_valid  = 1'b1;
        cmd_type   = 3'd0;
        cmd_q      = 4'd7;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (rn16_update) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reset_mid_reach: rn16_update never rose within 30 cycles, want it high");
        end
        #2 rst = 1'b1;
        #1;
        n_chk++;
        if (rn16_update !== 1'b0 || Q !== 4'd0 || cmd_ready !== 1'b1 || strb !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_mid: got rn16=%b Q=%0d rdy=%b strb=%b, want 0/0/1/0000",
                     rn16_update, Q, cmd_ready, strb);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        issue(3'd0, 4'd2, 3'd0, 1'b1, 1'b0);
        n_chk++;
        if (obs_kind !== 1 || obs_lat !== 11 || obs_type !== 1 || obs_seq !== 32'h13 || Q !== 4'd2) begin
            n_fail++;
            $display("FAIL after_reset_query: got kind=%0d lat=%0d type=%0d seq=%h Q=%0d, want 1/11/1/13/2",
                     obs_kind, obs_lat, obs_type, obs_seq, Q);
        end
    endtask

`ifdef RNG_SLOT_CNT_EN
    task automatic test_slot_cnt();
        issue(3'd0, 4'd3, 3'd0, 1'b0, 1'b0);
        repeat (3) issue(3'd1, 4'd0, 3'd0, 1'b0, 1'b0);
        n_chk++;
        if (slot_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL slot_cnt_rep: got %0d want 3", slot_cnt);
        end
        issue(3'd0, 4'd3, 3'd0, 1'b0, 1'b0);
        n_chk++;
        if (slot_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL slot_cnt_clear: got %0d want 0", slot_cnt);
        end
    endtask
`endif

    task automatic test_random();
        int m_q, e_kind, e_lat, e_typ, e_q;
        int unsigned e_seq;
        logic [2:0] t, ud;
        logic [3:0] cq;
        logic sv;
        m_q = 0;
        for (int n = 0; n < 40; n++) begin
            t  = (n == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            cq = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 3))
                0:       ud = 3'b110;
                1:       ud = 3'b011;
                2:       ud = 3'b000;
                default: ud = 3'($urandom_range(0, 7));
            endcase
            sv = 1'($urandom_range(0, 1));
            model(t, cq, ud, sv, m_q, e_kind, e_lat, e_typ, e_seq, e_q);
            issue(t, cq, ud, sv, 1'($urandom_range(0, 1)));
            n_chk++;
            if (obs_kind !== e_kind || obs_lat !== e_lat || (e_kind == 1 && obs_type !== e_typ) ||
                obs_seq !== e_seq || int'(Q) !== e_q || obs_after !== 3'b001) begin
                n_fail++;
                $display("FAIL random[%0d] t=%0d q=%0d ud=%b sv=%b: got kind=%0d lat=%0d type=%0d seq=%h Q=%0d after=%b, want %0d/%0d/%0d/%h/%0d/001",
                         n, t, cq, ud, sv, obs_kind, obs_lat, obs_type, obs_seq, Q, obs_after,
                         e_kind, e_lat, e_typ, e_seq, e_q);
            end
            m_q = e_q;
        end
    endtask

    initial begin
        test_reset();
        test_query_hit();
        test_query_miss();
        test_queryadj_sat();
        test_req();
        test_illegal();
        test_busy_ignore();
        test_reset_mid();
`ifdef RNG_SLOT_CNT_EN
        test_slot_cnt();
`endif
        test_random();
        n_chk++;
        if (mon_viol != 0) begin
            n_fail++;
            $display("FAIL strobe_monitor: got %0d overlap/width/gap violations, want 0", mon_viol);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
